program_loader: RTL

Host-side program-load engine for the SAP-1 microprocessor. It accepts a stream of program bytes over a valid/ready handshake and assigns consecutive memory addresses 0..15. It drives the microprocessor's programming interface (PROG_RUN, WRITE_ADDR, DATA_INPUT) and then sequences the CPU out of program mode and through its reset pulse. It sits between the host byte source and the Microprocessor inputs, replacing hand-driven load sequences.

---
 rtl/program_loader.sv | 108 ++++++++++
 1 files changed

// File: rtl/program_loader.sv
`default_nettype none
// program_loader (rev 1.0): streams MEM_DEPTH program bytes into the SAP-1 programming port,
// then drops PROG_RUN and sequences the CPU out of reset.
module program_loader #(
  parameter int MEM_DEPTH     = 16,
  parameter int ADDR_W        = 4,
  parameter int DATA_W        = 8,
  parameter int SETTLE_CYCLES = 2,
  parameter int RESET_HOLD    = 2
) (
  input  logic              CLOCK,
  input  logic              RESET,
  input  logic              START,
  input  logic [DATA_W-1:0] BYTE_IN,
  input  logic              BYTE_VALID,
  output logic              BYTE_READY,
  output logic              PROG_RUN,
  output logic [ADDR_W-1:0] WRITE_ADDR,
  output logic [DATA_W-1:0] DATA_INPUT,
  output logic              CPU_RESET,
  output logic              BUSY,
  output logic              DONE
);

  localparam int TMR_MAX = (SETTLE_CYCLES > RESET_HOLD) ? SETTLE_CYCLES : RESET_HOLD;
  localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

  localparam logic [ADDR_W-1:0] LAST_ADDR   = ADDR_W'(MEM_DEPTH - 1);
  localparam logic [TMR_W-1:0]  SETTLE_LAST = TMR_W'(SETTLE_CYCLES - 1);
  localparam logic [TMR_W-1:0]  RESET_LAST  = TMR_W'(RESET_HOLD - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    SETTLE  = 3'd2,
    CPU_RST = 3'd3,
    RUN     = 3'd4
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] cnt;
  logic [TMR_W-1:0]  tmr;

  always_ff @(posedge CLOCK) begin
    if (!RESET) begin
      state      <= IDLE;
      cnt        <= '0;
      tmr        <= '0;
      PROG_RUN   <= 1'b1;
      CPU_RESET  <= 1'b0;
      WRITE_ADDR <= '0;
      DATA_INPUT <= '0;
      BYTE_READY <= 1'b0;
      BUSY       <= 1'b0;
      DONE       <= 1'b0;
    end else begin
      case (state)
        IDLE, RUN: begin
          // A new session re-enters program mode and holds the CPU in reset at once
          if (START) begin
            state      <= LOAD;
            cnt        <= '0;
            PROG_RUN   <= 1'b1;
            CPU_RESET  <= 1'b0;
            BYTE_READY <= 1'b1;
            BUSY       <= 1'b1;
            DONE       <= 1'b0;
          end
        end
        LOAD: begin
          if (BYTE_VALID && BYTE_READY) begin
            WRITE_ADDR <= cnt;
            DATA_INPUT <= BYTE_IN;
            if (cnt == LAST_ADDR) begin
              state      <= SETTLE;
              BYTE_READY <= 1'b0;
              tmr        <= '0;
            end else begin
              cnt <= cnt + ADDR_W'(1);
            end
          end
        end
        SETTLE: begin
          if (tmr == SETTLE_LAST) begin
            PROG_RUN <= 1'b0;
            tmr      <= '0;
            state    <= CPU_RST;
          end else begin
            tmr <= tmr + TMR_W'(1);
          end
        end
        CPU_RST: begin
          if (tmr == RESET_LAST) begin
            CPU_RESET <= 1'b1;
            DONE      <= 1'b1;
            BUSY      <= 1'b0;
            state     <= RUN;
          end else begin
            tmr <= tmr + TMR_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
